// File: rtl/mem_alloc_pool.sv
// mem_alloc_pool: per-channel free-address FIFOs filled by the host, a delete FIFO
// filled by the pipeline, occupancy/watermark status and a flush handshake FSM.
module mem_alloc_pool #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LOW_WM     = 8
) (
    input  logic                                            ACLK,
    input  logic                                            rst,
    input  logic [ADDR_W-1:0]                               host_free_data,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  host_free_ch,
    input  logic                                            host_free_valid,
    output logic                                            host_free_ready,
    output logic [ADDR_W-1:0]                               host_del_data,
    output logic                                            host_del_valid,
    input  logic                                            host_del_ready,
    output logic [NUM_CH*ADDR_W-1:0]                        alloc_data,
    output logic [NUM_CH-1:0]                               alloc_valid,
    input  logic [NUM_CH-1:0]                               alloc_ready,
    input  logic [ADDR_W-1:0]                               reclaim_data,
    input  logic                                            reclaim_valid,
    output logic                                            reclaim_ready,
    output logic [NUM_CH*(DEPTH_LOG2+1)-1:0]                free_level,
    output logic [DEPTH_LOG2:0]                             del_level,
    output logic [NUM_CH-1:0]                               low_water,
    output logic                                            bad_ch,
    input  logic                                            flushReq,
    output logic                                            flushAck,
    input  logic                                            flushDone
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic              flush_ack_q, flush_ack_d;
    logic              bad_ch_q, bad_ch_d;

    logic [ADDR_W-1:0] free_mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  free_wr_q [NUM_CH];
    logic [PTR_W-1:0]  free_rd_q [NUM_CH];
    logic [PTR_W-1:0]  free_wr_d [NUM_CH];
    logic [PTR_W-1:0]  free_rd_d [NUM_CH];
    logic [PTR_W-1:0]  free_lvl_q [NUM_CH];
    logic [PTR_W-1:0]  free_lvl_d [NUM_CH];
    logic [NUM_CH-1:0] low_q, low_d;
    logic [NUM_CH-1:0] free_empty, free_full, free_push, free_pop;

    logic [ADDR_W-1:0] del_mem [DEPTH];
    logic [PTR_W-1:0]  del_wr_q, del_rd_q, del_wr_d, del_rd_d;
    logic [PTR_W-1:0]  del_lvl_q, del_lvl_d;
    logic              del_empty, del_full, del_push, del_pop;

    logic              run, ch_oob, sel_full;

    // Handshake outputs are forced low while rst is high, whatever the state.
    always_comb begin
        run        = (state_q == ST_RUN) && !rst;
        ch_oob     = int'(host_free_ch) >= NUM_CH;
        sel_full   = 1'b0;
        free_empty = '0;
        free_full  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            free_empty[i] = (free_wr_q[i] == free_rd_q[i]);
            free_full[i]  = (free_wr_q[i][DEPTH_LOG2] != free_rd_q[i][DEPTH_LOG2]) &&
                            (free_wr_q[i][DEPTH_LOG2-1:0] == free_rd_q[i][DEPTH_LOG2-1:0]);
            if (host_free_ch == CH_W'(i)) begin
                sel_full = free_full[i];
            end
        end
        del_empty = (del_wr_q == del_rd_q);
        del_full  = (del_wr_q[DEPTH_LOG2] != del_rd_q[DEPTH_LOG2]) &&
                    (del_wr_q[DEPTH_LOG2-1:0] == del_rd_q[DEPTH_LOG2-1:0]);

        host_free_ready = run && (ch_oob || !sel_full);
        reclaim_ready   = run && !del_full;
        host_del_valid  = run && !del_empty;
        host_del_data   = del_mem[del_rd_q[DEPTH_LOG2-1:0]];
        alloc_valid     = '0;
        alloc_data      = '0;
        free_level      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            alloc_valid[i]                     = run && !free_empty[i];
            alloc_data[i*ADDR_W +: ADDR_W]     = free_mem[i][free_rd_q[i][DEPTH_LOG2-1:0]];
            free_level[i*PTR_W +: PTR_W]       = free_lvl_q[i];
        end
        del_level = del_lvl_q;
        low_water = low_q;
        bad_ch    = bad_ch_q;
        flushAck  = flush_ack_q && !rst;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (flushReq)  state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_WAIT;
            ST_WAIT:  if (flushDone) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        flush_ack_d = (state_q == ST_CLEAR);
        bad_ch_d    = bad_ch_q || (host_free_valid && host_free_ready && ch_oob);
    end

    // Pointer and level next-state; CLEAR overrides everything to empty.
    always_comb begin
        free_push = '0;
        free_pop  = '0;
        low_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            free_push[i] = host_free_valid && host_free_ready && !ch_oob &&
                           (host_free_ch == CH_W'(i));
            free_pop[i]  = alloc_valid[i] && alloc_ready[i];
            free_wr_d[i] = free_wr_q[i] + PTR_W'(free_push[i]);
            free_rd_d[i] = free_rd_q[i] + PTR_W'(free_pop[i]);
            if (state_q == ST_CLEAR) begin
                free_wr_d[i] = '0;
                free_rd_d[i] = '0;
            end
            free_lvl_d[i] = free_wr_d[i] - free_rd_d[i];
            low_d[i]      = int'(free_lvl_d[i]) < LOW_WM;
        end
        del_push = reclaim_valid && reclaim_ready;
        del_pop  = host_del_valid && host_del_ready;
        del_wr_d = del_wr_q + PTR_W'(del_push);
        del_rd_d = del_rd_q + PTR_W'(del_pop);
        if (state_q == ST_CLEAR) begin
            del_wr_d = '0;
            del_rd_d = '0;
        end
        del_lvl_d = del_wr_d - del_rd_d;
    end

    always_ff @(posedge ACLK) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_ack_q <= 1'b0;
            bad_ch_q    <= 1'b0;
            low_q       <= (LOW_WM > 0) ? '1 : '0;
            del_wr_q    <= '0;
            del_rd_q    <= '0;
            del_lvl_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                free_wr_q[i]  <= '0;
                free_rd_q[i]  <= '0;
                free_lvl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_ack_q <= flush_ack_d;
            bad_ch_q    <= bad_ch_d;
            low_q       <= low_d;
            del_wr_q    <= del_wr_d;
            del_rd_q    <= del_rd_d;
            del_lvl_q   <= del_lvl_d;
            for (int i = 0; i < NUM_CH; i++) begin
                free_wr_q[i]  <= free_wr_d[i];
                free_rd_q[i]  <= free_rd_d[i];
                free_lvl_q[i] <= free_lvl_d[i];
            end
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (free_push[i]) begin
                free_mem[i][free_wr_q[i][DEPTH_LOG2-1:0]] <= host_free_data;
            end
        end
        if (del_push) begin
            del_mem[del_wr_q[DEPTH_LOG2-1:0]] <= reclaim_data;
        end
    end

endmodule

// File: tb/tb_mem_alloc_pool.sv
// Randomized bench for mem_alloc_pool against a queue-based reference model.
module tb_mem_alloc_pool;
    localparam int NUM_CH     = 3;
    localparam int ADDR_W     = 32;
    localparam int DEPTH_LOG2 = 6;
    localparam int LOW_WM     = 8;
    localparam int CH_W       = 2;
    localparam int LVL_W      = DEPTH_LOG2 + 1;
    localparam int DEPTH      = 64;

    logic                       ACLK = 1'b0;
    logic                       rst;
    logic [ADDR_W-1:0]          host_free_data;
    logic [CH_W-1:0]            host_free_ch;
    logic                       host_free_valid;
    logic                       host_free_ready;
    logic [ADDR_W-1:0]          host_del_data;
    logic                       host_del_valid;
    logic                       host_del_ready;
    logic [NUM_CH*ADDR_W-1:0]   alloc_data;
    logic [NUM_CH-1:0]          alloc_valid;
    logic [NUM_CH-1:0]          alloc_ready;
    logic [ADDR_W-1:0]          reclaim_data;
    logic                       reclaim_valid;
    logic                       reclaim_ready;
    logic [NUM_CH*LVL_W-1:0]    free_level;
    logic [LVL_W-1:0]           del_level;
    logic [NUM_CH-1:0]          low_water;
    logic                       bad_ch;
    logic                       flushReq;
    logic                       flushAck;
    logic                       flushDone;

    always #5 ACLK = ~ACLK;

    mem_alloc_pool #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .LOW_WM(LOW_WM)
    ) dut (
        .ACLK(ACLK), .rst(rst),
        .host_free_data(host_free_data), .host_free_ch(host_free_ch),
        .host_free_valid(host_free_valid), .host_free_ready(host_free_ready),
        .host_del_data(host_del_data), .host_del_valid(host_del_valid),
        .host_del_ready(host_del_ready),
        .alloc_data(alloc_data), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .reclaim_data(reclaim_data), .reclaim_valid(reclaim_valid),
        .reclaim_ready(reclaim_ready),
        .free_level(free_level), .del_level(del_level), .low_water(low_water),
        .bad_ch(bad_ch), .flushReq(flushReq), .flushAck(flushAck), .flushDone(flushDone)
    );

    // Reference model: plain queues plus the flush phase (0 run, 1 clear, 2 wait).
    logic [ADDR_W-1:0] fq [NUM_CH][$];
    logic [ADDR_W-1:0] dq [$];
    int                phase;
    bit                m_bad;
    bit                m_ack;
    int                n_checks;
    int                n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        bit                      run, free_ok, rec_ok, del_v, free_acc, rec_acc, del_acc;
        bit                      rst_s, freq_s, fdone_s;
        int                      ch;
        logic [ADDR_W-1:0]       fdata, rdata;
        logic [NUM_CH-1:0]       exp_av, exp_lw, pop_acc;
        logic [NUM_CH*LVL_W-1:0] exp_lvl;
        @(negedge ACLK);
        run = (phase == 0) && !rst;
        ch  = int'(host_free_ch);
        free_ok = (ch >= NUM_CH) ? 1'b1 : (fq[ch].size() < DEPTH);
        rec_ok  = dq.size() < DEPTH;
        del_v   = run && (dq.size() > 0);
        exp_lvl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            exp_av[i] = run && (fq[i].size() > 0);
            exp_lw[i] = fq[i].size() < LOW_WM;
            exp_lvl[i*LVL_W +: LVL_W] = LVL_W'(fq[i].size());
            if (exp_av[i])
                check($sformatf("alloc_data%0d", i), 64'(alloc_data[i*ADDR_W +: ADDR_W]), 64'(fq[i][0]));
        end
        check("host_free_ready", 64'(host_free_ready), 64'(run && free_ok));
        check("reclaim_ready", 64'(reclaim_ready), 64'(run && rec_ok));
        check("alloc_valid", 64'(alloc_valid), 64'(exp_av));
        check("free_level", 64'(free_level), 64'(exp_lvl));
        check("low_water", 64'(low_water), 64'(exp_lw));
        check("host_del_valid", 64'(host_del_valid), 64'(del_v));
        if (del_v) check("host_del_data", 64'(host_del_data), 64'(dq[0]));
        check("del_level", 64'(del_level), 64'(dq.size()));
        check("bad_ch", 64'(bad_ch), 64'(m_bad));
        check("flushAck", 64'(flushAck), 64'(m_ack && !rst));

        free_acc = run && free_ok && host_free_valid;
        rec_acc  = run && rec_ok && reclaim_valid;
        del_acc  = del_v && host_del_ready;
        pop_acc  = exp_av & alloc_ready;
        rst_s = rst; freq_s = flushReq; fdone_s = flushDone;
        fdata = host_free_data; rdata = reclaim_data;
        @(posedge ACLK);
        if (rst_s) begin
            for (int i = 0; i < NUM_CH; i++) fq[i].delete();
            dq.delete();
            phase = 0; m_bad = 0; m_ack = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) if (pop_acc[i]) void'(fq[i].pop_front());
            if (del_acc) void'(dq.pop_front());
            if (rec_acc) dq.push_back(rdata);
            if (free_acc) begin
                if (ch >= NUM_CH) m_bad = 1;
                else fq[ch].push_back(fdata);
            end
            m_ack = (phase == 1);
            case (phase)
                0: if (freq_s) phase = 1;
                1: begin
                    for (int i = 0; i < NUM_CH; i++) fq[i].delete();
                    dq.delete();
                    phase = 2;
                end
                default: if (fdone_s) phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic idle();
        host_free_valid = 0; alloc_ready = '0; reclaim_valid = 0;
        host_del_ready = 0; flushReq = 0; flushDone = 0;
    endtask

    task automatic push_free(input int ch, input logic [ADDR_W-1:0] data);
        host_free_ch = CH_W'(ch); host_free_data = data; host_free_valid = 1;
        tick();
        host_free_valid = 0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; phase = 0; m_bad = 0; m_ack = 0;
        rst = 1; host_free_data = '0; host_free_ch = '0; reclaim_data = '0;
        idle();
        repeat (2) tick();
        rst = 0;
        tick();

        // Basic push to two channels, then pop both.
        push_free(0, 32'h1000);
        push_free(1, 32'h2000);
        tick();
        alloc_ready = 3'b011; tick();
        idle(); tick();

        // Fill channel 0 to capacity; further pushes stall, other channels stay ready.
        for (int i = 0; i < DEPTH; i++) push_free(0, $urandom);
        host_free_ch = 2'd0; host_free_valid = 1; host_free_data = 32'hDEAD_0001;
        repeat (2) tick();
        host_free_valid = 0; host_free_ch = 2'd1; tick();
        alloc_ready = 3'b001; tick();
        idle(); host_free_ch = 2'd0; tick();
        alloc_ready = 3'b001; repeat (DEPTH + 2) tick();
        idle();

        // Wrap channel 1 with interleaved random pushes, pops and stalls.
        for (int i = 0; i < 200; i++) begin
            host_free_ch    = 2'd1;
            host_free_data  = $urandom;
            host_free_valid = $urandom_range(0, 1);
            alloc_ready     = {1'b0, 1'($urandom_range(0, 1)), 1'b0};
            tick();
        end
        idle(); alloc_ready = 3'b010; repeat (DEPTH + 2) tick();
        idle();

        // Out-of-range channel: accepted, discarded, sticky flag.
        push_free(3, 32'hBAD0_0003);
        tick();

        // Flush with data in channel 0 and the delete FIFO.
        for (int i = 0; i < 10; i++) push_free(0, 32'h3000 + i);
        for (int i = 0; i < 5; i++) begin
            reclaim_data = 32'h4000 + i; reclaim_valid = 1; tick();
        end
        reclaim_valid = 0;
        flushReq = 1; tick();
        flushReq = 0;
        host_free_valid = 1; reclaim_valid = 1; alloc_ready = '1; host_del_ready = 1;
        repeat (4) tick();
        idle(); flushDone = 1; tick();
        flushDone = 0; repeat (2) tick();

        // Reset while waiting for flushDone.
        push_free(2, 32'h5000);
        flushReq = 1; tick();
        flushReq = 0; tick();
        rst = 1; tick();
        rst = 0; repeat (2) tick();

        // Mixed random traffic including flushes and rare resets.
        for (int i = 0; i < 600; i++) begin
            host_free_ch    = ($urandom_range(0, 19) == 0) ? 2'd3 : CH_W'($urandom_range(0, 2));
            host_free_data  = $urandom;
            host_free_valid = $urandom_range(0, 3) != 0;
            alloc_ready     = NUM_CH'($urandom);
            reclaim_data    = $urandom;
            reclaim_valid   = $urandom_range(0, 1);
            host_del_ready  = $urandom_range(0, 2) == 0;
            flushReq        = $urandom_range(0, 99) < 3;
            flushDone       = $urandom_range(0, 99) < 30;
            rst             = $urandom_range(0, 199) == 0;
            tick();
        end
        rst = 0; idle(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
